// File: rtl/pic_pkg.sv
// pic_pkg: shared definitions for the 8259A-compatible PIC command path.
//   - pic_state_e : initialisation / command FSM states
//   - rd_sel_e    : read-back selection (IRR or ISR)
//   - bit indices used to decode ICW1 and the OCWs
//   - commit-flag vector indices
package pic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_ICW2 = 3'd1,
    ST_WAIT_ICW3 = 3'd2,
    ST_WAIT_ICW4 = 3'd3,
    ST_READY     = 3'd4
  } pic_state_e;

  typedef enum logic {
    RD_SEL_IRR = 1'b0,
    RD_SEL_ISR = 1'b1
  } rd_sel_e;

  // ICW1 fields
  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;

  // Command-byte decode bits (D4 marks ICW1, D3 separates OCW3 from OCW2)
  localparam int CMD_D4 = 4;
  localparam int OCW_D3 = 3;

  // OCW3 read-register fields: RR enables the change, RIS picks ISR over IRR
  localparam int OCW3_RIS = 0;
  localparam int OCW3_RR  = 1;

  // Commit-flag vector layout
  localparam int NUM_FLAGS = 7;
  localparam int FLAG_ICW1 = 0;
  localparam int FLAG_ICW2 = 1;
  localparam int FLAG_ICW3 = 2;
  localparam int FLAG_ICW4 = 3;
  localparam int FLAG_OCW1 = 4;
  localparam int FLAG_OCW2 = 5;
  localparam int FLAG_OCW3 = 6;

endpackage

// File: rtl/bus_synchronizer.sv
// bus_synchronizer: STAGES-deep flop chain bringing one asynchronous bus
// bit into the clk domain.
//   clk   : system clock
//   rst_n : asynchronous active-low reset, chain loads RESET_VAL
//   d     : asynchronous input bit
//   q     : synchronised output (STAGES clk edges of latency)
module bus_synchronizer #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pic_command_sequencer.sv
// pic_command_sequencer: clocked CPU-bus front end of the PIC.
// Synchronises the bus strobes, commits each write on the trailing edge of
// write_bar, walks the ICW1..ICW4 initialisation sequence, classifies the
// OCWs, holds every command register and drives the read-back mux.
//   clk, reset_bar                        : clock, async active-low reset
//   chip_select_bar, read_bar, write_bar,
//   A0, data_bus_buffer_in                : asynchronous CPU bus
//   data_bus_buffer_out, data_bus_out_enable : registered read-back
//   irr, isr                              : status for read-back
//   ICW_n_flag, OCW_n_flag                : one-cycle commit pulses
//   icw1..icw4, ocw2, ocw3, imr           : last committed command values
//   init_done                             : initialisation complete
module pic_command_sequencer
  import pic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          SINGLE_ONLY = 1'b0
) (
  input  logic       clk,
  input  logic       reset_bar,
  input  logic       chip_select_bar,
  input  logic       read_bar,
  input  logic       write_bar,
  input  logic       A0,
  input  logic [7:0] data_bus_buffer_in,
  output logic [7:0] data_bus_buffer_out,
  output logic       data_bus_out_enable,
  input  logic [7:0] irr,
  input  logic [7:0] isr,
  output logic       ICW_1_flag,
  output logic       ICW_2_flag,
  output logic       ICW_3_flag,
  output logic       ICW_4_flag,
  output logic       OCW_1_flag,
  output logic       OCW_2_flag,
  output logic       OCW_3_flag,
  output logic [7:0] icw1,
  output logic [7:0] icw2,
  output logic [7:0] icw3,
  output logic [7:0] icw4,
  output logic [7:0] ocw2,
  output logic [7:0] ocw3,
  output logic [7:0] imr,
  output logic       init_done
);

  // ---------------------------------------------------------------------------
  // Bus synchronisers (strobes idle high, A0/data idle low)
  // ---------------------------------------------------------------------------
  logic       cs_s, rd_s, wr_s, a0_s;
  logic [7:0] data_s;

  bus_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(reset_bar), .d(chip_select_bar), .q(cs_s));
  bus_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_rd (
    .clk(clk), .rst_n(reset_bar), .d(read_bar), .q(rd_s));
  bus_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_wr (
    .clk(clk), .rst_n(reset_bar), .d(write_bar), .q(wr_s));
  bus_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_a0 (
    .clk(clk), .rst_n(reset_bar), .d(A0), .q(a0_s));

  for (genvar b = 0; b < 8; b++) begin : g_sync_data
    bus_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_d (
      .clk(clk), .rst_n(reset_bar), .d(data_bus_buffer_in[b]), .q(data_s[b]));
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  pic_state_e           state_q, state_d;
  logic                 wr_low_q, wr_low_d;     // synced write_bar was low last cycle
  logic                 cs_ok_q, cs_ok_d;       // chip select held low for the whole low phase
  logic                 cap_a0_q, cap_a0_d;
  logic [7:0]           cap_data_q, cap_data_d;
  logic [7:0]           icw1_q, icw1_d, icw2_q, icw2_d, icw3_q, icw3_d, icw4_q, icw4_d;
  logic [7:0]           ocw2_q, ocw2_d, ocw3_q, ocw3_d, imr_q, imr_d;
  rd_sel_e              rd_sel_q, rd_sel_d;
  logic                 init_done_q, init_done_d;
  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic [7:0]           dout_q, dout_d;
  logic                 dout_en_q, dout_en_d;

  logic                 commit;
  logic                 read_active;
  logic [7:0]           read_mux;

  // A write commits on the cycle synced write_bar returns high; the decoded
  // byte is the one captured on the last low cycle.
  assign commit      = wr_s && wr_low_q && cs_ok_q;
  // An active write strobe suppresses the read.
  assign read_active = !cs_s && !rd_s && wr_s;

  always_comb begin
    read_mux = '0;
    if (a0_s) begin
      read_mux = imr_q;
    end else if (rd_sel_q == RD_SEL_ISR) begin
      read_mux = isr;
    end else begin
      read_mux = irr;
    end
  end

  // NOTE: every signal assigned here gets its default first, so no path can
  // leave a _d value unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    wr_low_d    = !wr_s;
    cs_ok_d     = cs_ok_q;
    cap_a0_d    = cap_a0_q;
    cap_data_d  = cap_data_q;
    icw1_d      = icw1_q;
    icw2_d      = icw2_q;
    icw3_d      = icw3_q;
    icw4_d      = icw4_q;
    ocw2_d      = ocw2_q;
    ocw3_d      = ocw3_q;
    imr_d       = imr_q;
    rd_sel_d    = rd_sel_q;
    init_done_d = init_done_q;
    flags_d     = '0;
    dout_en_d   = read_active;
    dout_d      = read_active ? read_mux : 8'h00;

    // Low phase: track chip select and keep the latest A0/data sample.
    if (!wr_s) begin
      cap_a0_d   = a0_s;
      cap_data_d = data_s;
      cs_ok_d    = wr_low_q ? (cs_ok_q && !cs_s) : !cs_s;
    end

    if (commit) begin
      if (!cap_a0_q && cap_data_q[CMD_D4]) begin
        // ICW1 restarts the sequence from any state.
        icw1_d              = cap_data_q;
        icw2_d              = '0;
        icw3_d              = '0;
        icw4_d              = '0;
        ocw2_d              = '0;
        ocw3_d              = '0;
        imr_d               = '0;
        rd_sel_d            = RD_SEL_IRR;
        init_done_d         = 1'b0;
        state_d             = ST_WAIT_ICW2;
        flags_d[FLAG_ICW1]  = 1'b1;
      end else begin
        unique case (state_q)
          ST_WAIT_ICW2: if (cap_a0_q) begin
            icw2_d             = cap_data_q;
            flags_d[FLAG_ICW2] = 1'b1;
            if (!icw1_q[ICW1_SNGL] && !SINGLE_ONLY) begin
              state_d = ST_WAIT_ICW3;
            end else if (icw1_q[ICW1_IC4]) begin
              state_d = ST_WAIT_ICW4;
            end else begin
              state_d     = ST_READY;
              init_done_d = 1'b1;
            end
          end
          ST_WAIT_ICW3: if (cap_a0_q) begin
            icw3_d             = cap_data_q;
            flags_d[FLAG_ICW3] = 1'b1;
            if (icw1_q[ICW1_IC4]) begin
              state_d = ST_WAIT_ICW4;
            end else begin
              state_d     = ST_READY;
              init_done_d = 1'b1;
            end
          end
          ST_WAIT_ICW4: if (cap_a0_q) begin
            icw4_d             = cap_data_q;
            flags_d[FLAG_ICW4] = 1'b1;
            state_d            = ST_READY;
            init_done_d        = 1'b1;
          end
          ST_READY: begin
            if (cap_a0_q) begin
              imr_d              = cap_data_q;
              flags_d[FLAG_OCW1] = 1'b1;
            end else if (cap_data_q[OCW_D3]) begin
              ocw3_d             = cap_data_q;
              flags_d[FLAG_OCW3] = 1'b1;
              if (cap_data_q[OCW3_RR]) begin
                rd_sel_d = cap_data_q[OCW3_RIS] ? RD_SEL_ISR : RD_SEL_IRR;
              end
            end else begin
              ocw2_d             = cap_data_q;
              flags_d[FLAG_OCW2] = 1'b1;
            end
          end
          default: ;  // IDLE: only ICW1 is accepted
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state_q     <= ST_IDLE;
      wr_low_q    <= 1'b0;
      cs_ok_q     <= 1'b0;
      cap_a0_q    <= 1'b0;
      cap_data_q  <= '0;
      icw1_q      <= '0;
      icw2_q      <= '0;
      icw3_q      <= '0;
      icw4_q      <= '0;
      ocw2_q      <= '0;
      ocw3_q      <= '0;
      imr_q       <= '0;
      rd_sel_q    <= RD_SEL_IRR;
      init_done_q <= 1'b0;
      flags_q     <= '0;
      dout_q      <= '0;
      dout_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_low_q    <= wr_low_d;
      cs_ok_q     <= cs_ok_d;
      cap_a0_q    <= cap_a0_d;
      cap_data_q  <= cap_data_d;
      icw1_q      <= icw1_d;
      icw2_q      <= icw2_d;
      icw3_q      <= icw3_d;
      icw4_q      <= icw4_d;
      ocw2_q      <= ocw2_d;
      ocw3_q      <= ocw3_d;
      imr_q       <= imr_d;
      rd_sel_q    <= rd_sel_d;
      init_done_q <= init_done_d;
      flags_q     <= flags_d;
      dout_q      <= dout_d;
      dout_en_q   <= dout_en_d;
    end
  end

  assign ICW_1_flag          = flags_q[FLAG_ICW1];
  assign ICW_2_flag          = flags_q[FLAG_ICW2];
  assign ICW_3_flag          = flags_q[FLAG_ICW3];
  assign ICW_4_flag          = flags_q[FLAG_ICW4];
  assign OCW_1_flag          = flags_q[FLAG_OCW1];
  assign OCW_2_flag          = flags_q[FLAG_OCW2];
  assign OCW_3_flag          = flags_q[FLAG_OCW3];
  assign icw1                = icw1_q;
  assign icw2                = icw2_q;
  assign icw3                = icw3_q;
  assign icw4                = icw4_q;
  assign ocw2                = ocw2_q;
  assign ocw3                = ocw3_q;
  assign imr                 = imr_q;
  assign init_done           = init_done_q;
  assign data_bus_buffer_out = dout_q;
  assign data_bus_out_enable = dout_en_q;

endmodule

// File: tb/tb_pic_command_sequencer.sv
// tb_pic_command_sequencer: drives three DUT instances from one CPU bus
//   inst 0: SYNC_STAGES=2, SINGLE_ONLY=0
//   inst 1: SYNC_STAGES=3, SINGLE_ONLY=0
//   inst 2: SYNC_STAGES=2, SINGLE_ONLY=1
// and compares them against a command-level model of the PIC register file.
module tb_pic_command_sequencer;

  logic       clk = 1'b0;
  logic       reset_bar = 1'b0;
  logic       chip_select_bar = 1'b1;
  logic       read_bar = 1'b1;
  logic       write_bar = 1'b1;
  logic       a0 = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] irr = 8'h00;
  logic [7:0] isr = 8'h00;

  logic [7:0] dout [3];
  logic       den  [3];
  logic [6:0] flg  [3];
  logic [7:0] r_icw1 [3], r_icw2 [3], r_icw3 [3], r_icw4 [3];
  logic [7:0] r_ocw2 [3], r_ocw3 [3], r_imr [3];
  logic       r_done [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pic_command_sequencer #(
      .SYNC_STAGES((g == 1) ? 3 : 2),
      .SINGLE_ONLY(g == 2)
    ) u_dut (
      .clk                 (clk),
      .reset_bar           (reset_bar),
      .chip_select_bar     (chip_select_bar),
      .read_bar            (read_bar),
      .write_bar           (write_bar),
      .A0                  (a0),
      .data_bus_buffer_in  (din),
      .data_bus_buffer_out (dout[g]),
      .data_bus_out_enable (den[g]),
      .irr                 (irr),
      .isr                 (isr),
      .ICW_1_flag          (flg[g][0]),
      .ICW_2_flag          (flg[g][1]),
      .ICW_3_flag          (flg[g][2]),
      .ICW_4_flag          (flg[g][3]),
      .OCW_1_flag          (flg[g][4]),
      .OCW_2_flag          (flg[g][5]),
      .OCW_3_flag          (flg[g][6]),
      .icw1                (r_icw1[g]),
      .icw2                (r_icw2[g]),
      .icw3                (r_icw3[g]),
      .icw4                (r_icw4[g]),
      .ocw2                (r_ocw2[g]),
      .ocw3                (r_ocw3[g]),
      .imr                 (r_imr[g]),
      .init_done           (r_done[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: v=0 supports cascade, v=1 is single-only.
  // After ICW1 the model lists which ICWs are still owed and fills them in
  // order; once the list is exhausted the bus carries OCWs.
  // ---------------------------------------------------------------------------
  logic [7:0] m_icw [2][1:4];
  logic [7:0] m_imr [2], m_ocw2 [2], m_ocw3 [2];
  bit         m_sel_isr [2];
  bit         m_started [2];
  int         m_seq [2][3];
  int         m_len [2], m_pos [2];

  function automatic int lat(int g);
    return (g == 1) ? 4 : 3;
  endfunction

  function automatic int mv(int g);
    return (g == 2) ? 1 : 0;
  endfunction

  function automatic bit m_done(int v);
    return m_started[v] && (m_pos[v] == m_len[v]);
  endfunction

  function automatic void model_reset();
    for (int v = 0; v < 2; v++) begin
      for (int k = 1; k <= 4; k++) m_icw[v][k] = 8'h00;
      m_imr[v] = 0; m_ocw2[v] = 0; m_ocw3[v] = 0;
      m_sel_isr[v] = 0; m_started[v] = 0; m_len[v] = 0; m_pos[v] = 0;
    end
  endfunction

  // Applies one committed write; returns the expected flag vector
  // (bit0..6 = ICW1..ICW4, OCW1..OCW3).
  function automatic logic [6:0] model_write(int v, logic wa0, logic [7:0] d);
    logic [6:0] f = '0;
    if (!wa0 && d[4]) begin
      m_icw[v][1] = d;
      for (int k = 2; k <= 4; k++) m_icw[v][k] = 8'h00;
      m_imr[v] = 0; m_ocw2[v] = 0; m_ocw3[v] = 0; m_sel_isr[v] = 0;
      m_started[v] = 1; m_pos[v] = 0; m_len[v] = 0;
      m_seq[v][m_len[v]++] = 2;
      if (!d[1] && v == 0) m_seq[v][m_len[v]++] = 3;
      if (d[0])            m_seq[v][m_len[v]++] = 4;
      f[0] = 1'b1;
    end else if (!m_started[v]) begin
      f = '0;
    end else if (m_pos[v] < m_len[v]) begin
      if (wa0) begin
        int k = m_seq[v][m_pos[v]];
        m_icw[v][k] = d;
        m_pos[v]++;
        f[k-1] = 1'b1;
      end
    end else if (wa0) begin
      m_imr[v] = d; f[4] = 1'b1;
    end else if (d[3]) begin
      m_ocw3[v] = d; f[6] = 1'b1;
      if (d[1]) m_sel_isr[v] = d[0];
    end else begin
      m_ocw2[v] = d; f[5] = 1'b1;
    end
    return f;
  endfunction

  function automatic logic [63:0] dut_regs(int g);
    return {7'd0, r_icw1[g], r_icw2[g], r_icw3[g], r_icw4[g],
            r_ocw2[g], r_ocw3[g], r_imr[g], r_done[g]};
  endfunction

  function automatic logic [63:0] model_regs(int v);
    return {7'd0, m_icw[v][1], m_icw[v][2], m_icw[v][3], m_icw[v][4],
            m_ocw2[v], m_ocw3[v], m_imr[v], m_done(v)};
  endfunction

  function automatic logic [7:0] model_read(int v, logic ra0);
    if (ra0) return m_imr[v];
    return m_sel_isr[v] ? isr : irr;
  endfunction

  task automatic check_regs(input string tag);
    for (int g = 0; g < 3; g++)
      check($sformatf("%s_regs%0d", tag, g), dut_regs(g), model_regs(mv(g)));
  endtask

  task automatic check_all_zero(input string tag);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("%s_regs%0d", tag, g), dut_regs(g), 64'd0);
      check($sformatf("%s_out%0d", tag, g), {47'd0, dout[g], den[g], flg[g]}, 64'd0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Bus tasks
  // ---------------------------------------------------------------------------
  task automatic do_write(input logic wa0, input logic [7:0] d,
                          input bit overlap, input bit cs_early);
    logic [6:0] ef [2];
    bit         dn_old [2], dn_new [2];
    for (int v = 0; v < 2; v++) begin
      dn_old[v] = m_done(v);
      ef[v]     = cs_early ? 7'd0 : model_write(v, wa0, d);
      dn_new[v] = m_done(v);
    end
    @(negedge clk);
    chip_select_bar = 1'b0; a0 = wa0; din = d; write_bar = 1'b0;
    if (overlap) read_bar = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    if (cs_early) begin
      chip_select_bar = 1'b1;
      repeat (2) @(negedge clk);
    end
    // Bus changes together with the trailing edge; the earlier byte must win.
    write_bar = 1'b1; read_bar = 1'b1; din = ~d; a0 = ~wa0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 3; g++) begin
        int  v  = mv(g);
        logic [6:0] expf = (k == lat(g)) ? ef[v] : 7'd0;
        logic       expd = (k >= lat(g)) ? dn_new[v] : dn_old[v];
        check($sformatf("wr_flags%0d_k%0d", g, k), {56'd0, r_done[g], flg[g]}, {56'd0, expd, expf});
        if (overlap) check($sformatf("ovl_en%0d_k%0d", g, k), {63'd0, den[g]}, 64'd0);
      end
    end
    @(negedge clk);
    chip_select_bar = 1'b1;
    check_regs("wr");
  endtask

  task automatic do_read(input logic ra0);
    @(negedge clk);
    chip_select_bar = 1'b0; read_bar = 1'b0; a0 = ra0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 3; g++) begin
        logic en = (k >= lat(g));
        check($sformatf("rd%0d_k%0d", g, k), {55'd0, dout[g], den[g]},
              {55'd0, en ? model_read(mv(g), ra0) : 8'h00, en});
      end
    end
    @(negedge clk);
    irr = 8'($urandom); isr = 8'($urandom);
    @(posedge clk); #1;
    for (int g = 0; g < 3; g++)
      check($sformatf("rd_track%0d", g), {55'd0, dout[g], den[g]},
            {55'd0, model_read(mv(g), ra0), 1'b1});
    @(negedge clk);
    read_bar = 1'b1; chip_select_bar = 1'b1;
    repeat (5) @(posedge clk); #1;
    for (int g = 0; g < 3; g++)
      check($sformatf("rd_idle%0d", g), {55'd0, dout[g], den[g]}, 64'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk); #2;
    reset_bar = 1'b0;
    #1;
    model_reset();
    check_all_zero("async_rst");
    @(negedge clk);
    reset_bar = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    model_reset();
    irr = 8'($urandom); isr = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_bar = 1'b1;

    // Non-ICW1 write while idle is ignored
    do_write(1'b1, 8'h55, 0, 0);

    // Single mode with ICW4
    do_write(1'b0, 8'h13, 0, 0);
    do_write(1'b1, 8'h20, 0, 0);
    do_write(1'b1, 8'h01, 0, 0);

    // OCWs and read-back
    do_write(1'b1, 8'hF0, 0, 0);
    do_write(1'b0, 8'h0B, 0, 0);
    isr = 8'h08;
    do_read(1'b0);
    do_write(1'b0, 8'h0A, 0, 0);
    irr = 8'h81;
    do_read(1'b0);
    do_read(1'b1);
    do_write(1'b0, 8'h20, 0, 0);   // OCW2

    // Cascade sequence (single-only instance routes 0x04 into icw4)
    do_write(1'b0, 8'h11, 0, 0);
    do_write(1'b0, 8'h00, 0, 0);   // ignored while waiting for ICW2
    do_write(1'b1, 8'h20, 0, 0);
    do_write(1'b1, 8'h04, 0, 0);
    do_write(1'b1, 8'h01, 0, 0);

    // ICW1 mid-sequence restarts and clears imr
    do_write(1'b0, 8'h11, 0, 0);
    do_write(1'b1, 8'h20, 0, 0);
    do_write(1'b0, 8'h13, 0, 0);
    do_write(1'b1, 8'h40, 0, 0);
    do_write(1'b1, 8'h03, 0, 0);

    // Reset while waiting for ICW3; next data write is ignored
    do_write(1'b0, 8'h11, 0, 0);
    do_write(1'b1, 8'h20, 0, 0);
    pulse_reset();
    do_write(1'b1, 8'h04, 0, 0);

    // Overlapping read/write strobes, and chip select released early
    do_write(1'b0, 8'h12, 1, 0);
    do_write(1'b1, 8'h30, 0, 1);
    do_write(1'b1, 8'h30, 1, 0);
    do_read(1'b0);

    // Randomised traffic
    for (int i = 0; i < 80; i++) begin
      int op = $urandom_range(0, 9);
      bit ovl = ($urandom_range(0, 7) == 0);
      bit cse = ($urandom_range(0, 9) == 0);
      case (op)
        0, 1:       do_write(1'b0, 8'($urandom) | 8'h10, ovl, cse);
        2, 3, 4, 5: do_write(1'b1, 8'($urandom), ovl, cse);
        6, 7:       do_write(1'b0, 8'($urandom), ovl, cse);
        default:    do_read(1'($urandom));
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
